dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the byte-addressed, 32-bit little-endian data memory. It shares the memory between the CPU MEM stage (port C) and an external loader/debug port (port X). It latches one request at a time and drives the memory strobes, address and write data as stable registered signals for a fixed number of cycles. It then returns registered read data with a one-cycle acknowledge, and stalls the CPU pipeline while its request is unserved.

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / external) data-memory arbiter with a fixed-latency access sequencer
// Ports: clk_i, rst_i (async, active-low); cpu_* and ext_* request ports (req/we/adr/wdata in,
// rdata/ack out); cpu_stall_o; err_o misalignment pulse; mem_wr_o/mem_re_o/mem_adr_o/mem_data_o
// registered memory controls; mem_data_i combinational memory read data.
// Optional: define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed C > X priority.
module dmem_arbiter #(
  parameter int ACC_CYC = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_adr_i,
  input  logic [31:0]       ext_wdata_i,
  output logic [31:0]       ext_rdata_o,
  output logic              ext_ack_o,
  output logic              err_o,
  output logic              mem_wr_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);
  localparam int CW = ACC_CYC > 1 ? $clog2(ACC_CYC) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic gnt;
  logic pick;
  logic sel_we;
  logic al;
  logic [ADDR_W-1:0] sel_adr;
  logic [31:0] sel_wdata;
`ifdef DMEM_ARB_RR_EN
  logic last;
  assign pick = (cpu_req_i & ext_req_i) ? ~last : ~cpu_req_i;
`else
  assign pick = ~cpu_req_i;
`endif
  assign sel_we      = pick ? ext_we_i : cpu_we_i;
  assign sel_adr     = pick ? ext_adr_i : cpu_adr_i;
  assign sel_wdata   = pick ? ext_wdata_i : cpu_wdata_i;
  assign al          = sel_adr[1:0] == 2'b00;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  // Strobes are only raised for aligned accesses, so at the end of ACCESS an active read strobe
  // means "capture rdata" and no strobe at all means the address was misaligned.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt         <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_re_o    <= 1'b0;
      mem_adr_o   <= '0;
      mem_data_o  <= '0;
      cpu_rdata_o <= '0;
      ext_rdata_o <= '0;
      cpu_ack_o   <= 1'b0;
      ext_ack_o   <= 1'b0;
      err_o       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cpu_req_i | ext_req_i) begin
          state      <= ACCESS;
          cnt        <= CW'(ACC_CYC - 1);
          gnt        <= pick;
          mem_adr_o  <= sel_adr;
          mem_wr_o   <= sel_we & al;
          mem_re_o   <= ~sel_we & al;
          mem_data_o <= sel_we ? sel_wdata : '0;
`ifdef DMEM_ARB_RR_EN
          last       <= pick;
`endif
        end
        ACCESS: if (cnt == '0) begin
          state     <= DONE;
          mem_wr_o  <= 1'b0;
          mem_re_o  <= 1'b0;
          cpu_ack_o <= ~gnt;
          ext_ack_o <= gnt;
          err_o     <= ~(mem_wr_o | mem_re_o);
          if (mem_re_o && !gnt) cpu_rdata_o <= mem_data_i;
          if (mem_re_o && gnt) ext_rdata_o <= mem_data_i;
        end else cnt <= cnt - CW'(1);
        default: begin
          state     <= IDLE;
          cpu_ack_o <= 1'b0;
          ext_ack_o <= 1'b0;
          err_o     <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter, instances with ACC_CYC=1 (k=0) and ACC_CYC=3 (k=1)
module tb_dmem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  logic cpu_req [2], cpu_we [2], cpu_ack [2], cpu_stall [2];
  logic ext_req [2], ext_we [2], ext_ack [2];
  logic err [2], mem_wr [2], mem_re [2];
  logic [31:0] cpu_adr [2], cpu_wdata [2], cpu_rdata [2];
  logic [31:0] ext_adr [2], ext_wdata [2], ext_rdata [2];
  logic [31:0] mem_adr [2], mem_dout [2], mem_din [2];
  logic [31:0] mem [2][16];
  logic [31:0] refm [2][16];
  logic [31:0] exp_rd [2][2];
  int acc [2] = '{1, 3};
  int errors = 0;
  int checks = 0;
  for (genvar g = 0; g < 2; g++) begin : u
    dmem_arbiter #(.ACC_CYC(2 * g + 1), .ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req[g]), .cpu_we_i(cpu_we[g]), .cpu_adr_i(cpu_adr[g]), .cpu_wdata_i(cpu_wdata[g]),
      .cpu_rdata_o(cpu_rdata[g]), .cpu_ack_o(cpu_ack[g]), .cpu_stall_o(cpu_stall[g]),
      .ext_req_i(ext_req[g]), .ext_we_i(ext_we[g]), .ext_adr_i(ext_adr[g]), .ext_wdata_i(ext_wdata[g]),
      .ext_rdata_o(ext_rdata[g]), .ext_ack_o(ext_ack[g]), .err_o(err[g]),
      .mem_wr_o(mem_wr[g]), .mem_re_o(mem_re[g]), .mem_adr_o(mem_adr[g]), .mem_data_o(mem_dout[g]),
      .mem_data_i(mem_din[g])
    );
    assign mem_din[g] = mem_re[g] ? mem[g][mem_adr[g][5:2]] : 32'h0;
  end
  always @(posedge clk_i)
    for (int k = 0; k < 2; k++)
      if (mem_wr[k]) mem[k][mem_adr[k][5:2]] <= mem_dout[k];
  task automatic do_reset;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) exp_rd[k] = '{32'h0, 32'h0};
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask
  // Drives one access on port p (0=C, 1=X) of instance k and observes it until ack.
  // bad counts protocol violations: wrong strobe, wrong address/data, wrong ack, stray err, bad stall.
  task automatic run(input int k, input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int stb, output logic [31:0] rd, output bit er, output int bad);
    lat = -1; stb = 0; rd = '0; er = 1'b0; bad = 0;
    if (p) begin ext_req[k] = 1'b1; ext_we[k] = w; ext_adr[k] = a; ext_wdata[k] = d; end
    else begin cpu_req[k] = 1'b1; cpu_we[k] = w; cpu_adr[k] = a; cpu_wdata[k] = d; end
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk_i);
      if (w ? mem_wr[k] : mem_re[k]) stb++;
      if (w ? mem_re[k] : mem_wr[k]) bad++;
      if ((mem_wr[k] || mem_re[k]) && mem_adr[k] !== a) bad++;
      if (mem_wr[k] && mem_dout[k] !== d) bad++;
      if (mem_re[k] && mem_dout[k] !== 32'h0) bad++;
      if (!p && cpu_stall[k] !== !cpu_ack[k]) bad++;
      if (p ? cpu_ack[k] : ext_ack[k]) bad++;
      if (p ? ext_ack[k] : cpu_ack[k]) begin
        lat = n; rd = p ? ext_rdata[k] : cpu_rdata[k]; er = err[k];
      end else if (err[k]) bad++;
    end
    cpu_req[k] = 1'b0;
    ext_req[k] = 1'b0;
    @(negedge clk_i);
  endtask
  task automatic test_reset;
    int hits;
    @(negedge clk_i);
    rst_i = 1'b0;
    cpu_req[0] = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cpu_ack[k], ext_ack[k], err[k], mem_wr[k], mem_re[k], mem_adr[k], mem_dout[k], cpu_rdata[k], ext_rdata[k]} !== '0)
        begin errors++; $display("FAIL reset_outputs k=%0d got wr=%b re=%b adr=%h data=%h ack=%b/%b exp all 0", k, mem_wr[k], mem_re[k], mem_adr[k], mem_dout[k], cpu_ack[k], ext_ack[k]); end
    end
    checks++;
    if (cpu_stall[0] !== 1'b1) begin errors++; $display("FAIL reset_stall_hi got=%b exp=1", cpu_stall[0]); end
    cpu_req[0] = 1'b0;
    #1;
    checks++;
    if (cpu_stall[0] !== 1'b0) begin errors++; $display("FAIL reset_stall_lo got=%b exp=0", cpu_stall[0]); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    ext_req[1] = 1'b1; ext_we[1] = 1'b0; ext_adr[1] = 32'h20;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (mem_re[1] !== 1'b1) begin errors++; $display("FAIL mid_access_re got=%b exp=1", mem_re[1]); end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({mem_re[1], mem_wr[1], mem_adr[1]} !== '0) begin errors++; $display("FAIL mid_reset_drop got re=%b wr=%b adr=%h exp 0", mem_re[1], mem_wr[1], mem_adr[1]); end
    ext_req[1] = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    hits = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (cpu_ack[1] || ext_ack[1] || err[1] || mem_re[1]) hits++;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL mid_reset_no_ack got=%0d exp=0", hits); end
    for (int k = 0; k < 2; k++) exp_rd[k] = '{32'h0, 32'h0};
  endtask
  task automatic test_write_read;
    int lat, stb, bad; logic [31:0] rd; bit er;
    run(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, stb, rd, er, bad);
    refm[0][4] = 32'hDEADBEEF;
    checks++;
    if (lat != 2 || stb != 1 || bad != 0 || er || rd !== exp_rd[0][0])
      begin errors++; $display("FAIL cpu_write lat=%0d stb=%0d bad=%0d err=%b exp lat=2 stb=1 bad=0 err=0", lat, stb, bad, er); end
    run(0, 1'b0, 1'b0, 32'h10, 32'h0, lat, stb, rd, er, bad);
    exp_rd[0][0] = refm[0][4];
    checks++;
    if (lat != 2 || stb != 1 || bad != 0 || er || rd !== 32'hDEADBEEF)
      begin errors++; $display("FAIL cpu_read lat=%0d stb=%0d bad=%0d rd=%h exp lat=2 stb=1 bad=0 rd=deadbeef", lat, stb, bad, rd); end
  endtask
  task automatic test_ext_read;
    int lat, stb, bad; logic [31:0] rd, v; bit er;
    v = $urandom;
    run(1, 1'b0, 1'b1, 32'h20, v, lat, stb, rd, er, bad);
    refm[1][8] = v;
    checks++;
    if (lat != 4 || stb != 3 || bad != 0) begin errors++; $display("FAIL acc3_write lat=%0d stb=%0d bad=%0d exp 4/3/0", lat, stb, bad); end
    run(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, stb, rd, er, bad);
    exp_rd[1][1] = v;
    checks++;
    if (lat != 4 || stb != 3 || bad != 0 || er || rd !== v)
      begin errors++; $display("FAIL ext_read lat=%0d stb=%0d bad=%0d rd=%h exp 4/3/0 rd=%h", lat, stb, bad, rd, v); end
  endtask
  task automatic test_misaligned;
    int lat, stb, bad; logic [31:0] rd; bit er;
    run(0, 1'b0, 1'b0, 32'h13, 32'h0, lat, stb, rd, er, bad);
    checks++;
    if (lat != 2 || stb != 0 || bad != 0 || !er || rd !== exp_rd[0][0])
      begin errors++; $display("FAIL misaligned lat=%0d stb=%0d bad=%0d err=%b rd=%h exp 2/0/0 err=1 rd=%h", lat, stb, bad, er, rd, exp_rd[0][0]); end
  endtask
  task automatic test_random;
    int lat, stb, bad; logic [31:0] rd, a, d; bit er, p, w, mis;
    int word;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        run(k, 1'($urandom_range(0, 1)), 1'b1, 32'(i * 4), d, lat, stb, rd, er, bad);
        refm[k][i] = d;
      end
      for (int i = 0; i < 30; i++) begin
        p = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        mis = $urandom_range(0, 5) == 0;
        word = $urandom_range(0, 15);
        a = 32'(word * 4 + (mis ? $urandom_range(1, 3) : 0));
        d = $urandom;
        run(k, p, w, a, d, lat, stb, rd, er, bad);
        if (w && !mis) refm[k][word] = d;
        if (!w && !mis) exp_rd[k][p] = refm[k][word];
        checks++;
        if (lat != acc[k] + 1 || stb != (mis ? 0 : acc[k]) || er != mis || bad != 0 || rd !== exp_rd[k][p])
          begin errors++; $display("FAIL rand k=%0d op=%0d p=%0d w=%0d a=%h got lat=%0d stb=%0d err=%b bad=%0d rd=%h exp lat=%0d stb=%0d err=%b rd=%h",
            k, i, p, w, a, lat, stb, er, bad, rd, acc[k] + 1, mis ? 0 : acc[k], mis, exp_rd[k][p]); end
      end
    end
  endtask
  task automatic test_tie;
    int tc, te, ec, ee;
    do_reset();
    tc = -1; te = -1;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_adr[0] = 32'h10;
    ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_adr[0] = 32'h20;
    for (int n = 1; n <= 20 && (tc < 0 || te < 0); n++) begin
      @(negedge clk_i);
      if (cpu_ack[0]) begin tc = n; cpu_req[0] = 1'b0; end
      if (ext_ack[0]) begin te = n; ext_req[0] = 1'b0; end
    end
    cpu_req[0] = 1'b0; ext_req[0] = 1'b0;
    @(negedge clk_i);
`ifdef DMEM_ARB_RR_EN
    ec = 5; ee = 2;
`else
    ec = 2; ee = 5;
`endif
    checks++;
    if (tc != ec || te != ee) begin errors++; $display("FAIL tie cpu_ack@%0d ext_ack@%0d exp %0d/%0d", tc, te, ec, ee); end
    checks++;
    if (cpu_rdata[0] !== refm[0][4] || ext_rdata[0] !== refm[0][8])
      begin errors++; $display("FAIL tie_rdata got %h/%h exp %h/%h", cpu_rdata[0], ext_rdata[0], refm[0][4], refm[0][8]); end
    exp_rd[0] = '{refm[0][4], refm[0][8]};
  endtask
  task automatic test_hold;
    int at [3];
    int na;
    na = 0; at = '{-1, -1, -1};
    ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_adr[0] = 32'h08;
    for (int n = 1; n <= 30 && na < 3; n++) begin
      @(negedge clk_i);
      if (ext_ack[0]) begin at[na] = n; na++; end
    end
    ext_req[0] = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (at[i] != acc[0] + 1 + i * (acc[0] + 2))
        begin errors++; $display("FAIL hold ack%0d got=%0d exp=%0d", i, at[i], acc[0] + 1 + i * (acc[0] + 2)); end
    end
    checks++;
    if (ext_rdata[0] !== refm[0][2]) begin errors++; $display("FAIL hold_rdata got=%h exp=%h", ext_rdata[0], refm[0][2]); end
  endtask
  task automatic test_both_cont;
    int at [4], pt [4];
    int na, dbl;
    bit xp;
    do_reset();
    na = 0; dbl = 0; at = '{-1, -1, -1, -1}; pt = '{-1, -1, -1, -1};
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_adr[1] = 32'h20;
    ext_req[1] = 1'b1; ext_we[1] = 1'b0; ext_adr[1] = 32'h24;
    for (int n = 1; n <= 40 && na < 4; n++) begin
      @(negedge clk_i);
      if (cpu_ack[1] && ext_ack[1]) dbl++;
      if (cpu_ack[1] || ext_ack[1]) begin at[na] = n; pt[na] = ext_ack[1] ? 1 : 0; na++; end
    end
    cpu_req[1] = 1'b0; ext_req[1] = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      xp = (i % 2) == 0;
`else
      xp = 1'b0;
`endif
      checks++;
      if (at[i] != acc[1] + 1 + i * (acc[1] + 2) || pt[i] != int'(xp))
        begin errors++; $display("FAIL cont ack%0d got cyc=%0d port=%0d exp cyc=%0d port=%0d", i, at[i], pt[i], acc[1] + 1 + i * (acc[1] + 2), xp); end
    end
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL cont_double_ack got=%0d exp=0", dbl); end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_adr[k] = '0; cpu_wdata[k] = '0;
      ext_req[k] = 1'b0; ext_we[k] = 1'b0; ext_adr[k] = '0; ext_wdata[k] = '0;
      exp_rd[k] = '{32'h0, 32'h0};
    end
    test_reset();
    test_write_read();
    test_ext_read();
    test_misaligned();
    test_random();
    test_tie();
    test_hold();
    test_both_cont();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
